// File: rtl/jzjpcc_mem_load_unit_pkg.sv
// Shared memory-stage definitions: load funct3 encodings, load FSM states and
// the byte-lane mask helper also used by the store formatter.
package jzjpcc_mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    // Lane bit3 is byte offset 0 (big-endian lane numbering on the bus).
    function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   byte_mask = 4'b1000 >> off;
            2'b01:   byte_mask = off[1] ? 4'b0011 : 4'b1100;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic load_f3_illegal(input logic [2:0] funct3);
        return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/jzjpcc_mem_load_unit_if.sv
// Word-read bus between the load unit (master) and memory (slave).
interface jzjpcc_mem_load_unit_if;
    logic        memReadReq;
    logic [29:0] memAddress;
    logic [3:0]  memByteMask;
    logic        memReadAck;
    logic [31:0] memReadData;

    modport master (output memReadReq, memAddress, memByteMask,
                    input  memReadAck, memReadData);
    modport slave  (input  memReadReq, memAddress, memByteMask,
                    output memReadAck, memReadData);
endinterface

// File: rtl/jzjpcc_mem_load_unit_extractor.sv
// Combinational load data extraction: picks the addressed byte/halfword/word
// from a bus word in memory lane order and sign- or zero-extends it.
module jzjpcc_load_extractor
    import jzjpcc_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_data,
    output logic [31:0] o_result
);
    logic [3:0][7:0] w_b;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    // w_b[k] is the byte at offset k; offset 0 sits in the top lane.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_b[k] = i_data[31-8*k -: 8];
    end

    assign w_byte = w_b[i_offset];
    assign w_half = i_offset[1] ? {w_b[3], w_b[2]} : {w_b[1], w_b[0]};

    always_comb begin
        case (i_funct3)
            LB:      o_result = {{24{w_byte[7]}}, w_byte};
            LBU:     o_result = {24'b0, w_byte};
            LH:      o_result = {{16{w_half[15]}}, w_half};
            LHU:     o_result = {16'b0, w_half};
            LW:      o_result = {w_b[3], w_b[2], w_b[1], w_b[0]};
            default: o_result = 32'b0;
        endcase
    end
endmodule

// File: rtl/jzjpcc_mem_load_unit.sv
// Memory-stage load unit: one outstanding word read, stall while busy, extended
// result pulse to writeback. JZJPCC_MISALIGNED_FAULT_EN enables misalignment faults.
module jzjpcc_mem_load_unit
    import jzjpcc_mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        loadValid_execute,
    input  logic [2:0]  funct3_execute,
    input  logic [31:0] bytewiseAddress_execute,
    input  logic [4:0]  rdIndex_execute,
    input  logic        flush,
    output logic        loadReady,
    output logic        stall,
    jzjpcc_mem_load_unit_if.master mem,
    output logic        loadValid_writeback,
    output logic [31:0] loadData_writeback,
    output logic [4:0]  rdIndex_writeback,
    output logic        loadFault
);
    localparam logic [15:0] WAIT_LIMIT = 16'(MAX_WAIT - 1);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic [4:0]  r_rd;
    logic [15:0] r_wait;
    logic        w_accept, w_reject, w_issue, w_timeout, w_ack, w_complete;
    logic [31:0] w_result;

    assign w_ack    = mem.memReadAck;
    assign w_accept = (r_state == IDLE) && loadValid_execute && !flush;

`ifdef JZJPCC_MISALIGNED_FAULT_EN
    assign w_reject = load_f3_illegal(funct3_execute)
                   || ((funct3_execute[1:0] == 2'b01) && bytewiseAddress_execute[0])
                   || ((funct3_execute[1:0] == 2'b10) && (bytewiseAddress_execute[1:0] != 2'b00));
`else
    assign w_reject = load_f3_illegal(funct3_execute);
`endif

    assign w_issue    = w_accept && !w_reject;
    assign w_timeout  = r_wait >= WAIT_LIMIT;
    assign w_complete = (r_state == REQ) && w_ack && !flush;

    jzjpcc_load_extractor u_extract (
        .i_funct3 (r_funct3),
        .i_offset (r_offset),
        .i_data   (mem.memReadData),
        .o_result (w_result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // A flush wins over a same-cycle timeout; DRAIN then times out silently.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_issue) w_state_nxt = REQ;
            REQ:     if (w_ack)          w_state_nxt = IDLE;
                     else if (flush)     w_state_nxt = DRAIN;
                     else if (w_timeout) w_state_nxt = IDLE;
            DRAIN:   if (w_ack || w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem.memReadReq = (r_state != IDLE);
        loadReady      = (r_state == IDLE);
        stall          = (r_state != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_funct3            <= 3'b0;
            r_offset            <= 2'b0;
            r_rd                <= 5'b0;
            r_wait              <= 16'b0;
            mem.memAddress      <= 30'b0;
            mem.memByteMask     <= 4'b0;
            loadValid_writeback <= 1'b0;
            loadData_writeback  <= 32'b0;
            rdIndex_writeback   <= 5'b0;
            loadFault           <= 1'b0;
        end else begin
            loadValid_writeback <= w_complete;
            loadFault           <= (w_accept && w_reject)
                                || ((r_state == REQ) && !w_ack && !flush && w_timeout);
            if (r_state == IDLE) r_wait <= 16'b0;
            else                 r_wait <= r_wait + 16'd1;
            if (w_issue) begin
                r_funct3        <= funct3_execute;
                r_offset        <= bytewiseAddress_execute[1:0];
                r_rd            <= rdIndex_execute;
                mem.memAddress  <= bytewiseAddress_execute[31:2];
                mem.memByteMask <= byte_mask(funct3_execute, bytewiseAddress_execute[1:0]);
            end
            if (w_complete) begin
                loadData_writeback <= w_result;
                rdIndex_writeback  <= r_rd;
            end
        end
    end
endmodule

// File: tb/tb_jzjpcc_mem_load_unit.sv
// Randomized self-checking bench for jzjpcc_mem_load_unit against a
// transaction-level reference model.
module tb_jzjpcc_mem_load_unit;
    localparam int MW = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        loadValid_execute;
    logic [2:0]  funct3_execute;
    logic [31:0] bytewiseAddress_execute;
    logic [4:0]  rdIndex_execute;
    logic        flush;
    logic        loadReady, stall;
    logic        loadValid_writeback;
    logic [31:0] loadData_writeback;
    logic [4:0]  rdIndex_writeback;
    logic        loadFault;

    jzjpcc_mem_load_unit_if mem_if ();

    jzjpcc_mem_load_unit #(.MAX_WAIT(MW)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .loadValid_execute       (loadValid_execute),
        .funct3_execute          (funct3_execute),
        .bytewiseAddress_execute (bytewiseAddress_execute),
        .rdIndex_execute         (rdIndex_execute),
        .flush                   (flush),
        .loadReady               (loadReady),
        .stall                   (stall),
        .mem                     (mem_if.master),
        .loadValid_writeback     (loadValid_writeback),
        .loadData_writeback      (loadData_writeback),
        .rdIndex_writeback       (rdIndex_writeback),
        .loadFault               (loadFault)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: reassemble the little-endian value, then shift/truncate/extend.
    function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [31:0] le;
        logic [7:0]  by;
        logic [15:0] hw;
        le = {d[7:0], d[15:8], d[23:16], d[31:24]};
        by = 8'(le >> (8 * off));
        hw = 16'(le >> (16 * off[1]));
        case (f3)
            3'b000:  return {{24{by[7]}}, by};
            3'b100:  return {24'b0, by};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b101:  return {16'b0, hw};
            default: return le;
        endcase
    endfunction

    function automatic logic [3:0] ref_mask(input logic [2:0] f3, input logic [1:0] off);
        int size, base;
        logic [3:0] m;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        base = (size == 1) ? int'(off) : (size == 2) ? 2 * int'(off[1]) : 0;
        m = 4'b0;
        for (int l = base; l < base + size; l++) m[3 - l] = 1'b1;
        return m;
    endfunction

    function automatic bit ref_bad(input logic [2:0] f3, input logic [1:0] off);
        bit bad;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
`ifdef JZJPCC_MISALIGNED_FAULT_EN
        if ((f3 == 3'b001 || f3 == 3'b101) && off[0]) bad = 1;
        if (f3 == 3'b010 && off != 2'b00) bad = 1;
`endif
        return bad;
    endfunction

    // Called at a negedge; returns at the negedge where the result pulse is visible.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                           input int ack_at, input int flush_at, input logic [31:0] data);
        bit drain = 0, done = 0, exp_wb = 0, exp_flt = 0, ack, fl;
        int k = 0;
        chk("ready_pre", loadReady, 1);
        loadValid_execute       = 1;
        funct3_execute          = f3;
        bytewiseAddress_execute = addr;
        rdIndex_execute         = rd;
        flush                   = 0;
        @(negedge clock);
        loadValid_execute       = 0;
        funct3_execute          = 3'($urandom);
        bytewiseAddress_execute = $urandom;
        rdIndex_execute         = 5'($urandom);
        if (ref_bad(f3, addr[1:0])) begin
            chk("bad_fault", loadFault, 1);
            chk("bad_req", mem_if.memReadReq, 0);
            chk("bad_wb", loadValid_writeback, 0);
            chk("bad_ready", loadReady, 1);
            return;
        end
        while (!done) begin
            chk("req", mem_if.memReadReq, 1);
            chk("stall", stall, 1);
            chk("addr", mem_if.memAddress, addr[31:2]);
            chk("mask", mem_if.memByteMask, ref_mask(f3, addr[1:0]));
            chk("wb_quiet", loadValid_writeback, 0);
            chk("flt_quiet", loadFault, 0);
            ack = (k == ack_at);
            fl  = (k == flush_at);
            mem_if.memReadAck  = ack;
            mem_if.memReadData = ack ? data : $urandom;
            flush = fl;
            if (!drain) begin
                if (ack) begin done = 1; exp_wb = !fl; end
                else if (fl) drain = 1;
                else if (k >= MW - 1) begin done = 1; exp_flt = 1; end
            end else if (ack || k >= MW - 1) done = 1;
            k++;
            @(negedge clock);
            if (k > 40 && !done) begin
                chk("cycle_bound", 32'(k), 0);
                done = 1;
            end
        end
        mem_if.memReadAck  = 0;
        mem_if.memReadData = $urandom;
        flush = 0;
        chk("wb", loadValid_writeback, 32'(exp_wb));
        if (exp_wb) begin
            chk("data", loadData_writeback, ref_data(f3, addr[1:0], data));
            chk("rd", rdIndex_writeback, rd);
        end
        chk("fault", loadFault, 32'(exp_flt));
        chk("ready_post", loadReady, 1);
        chk("req_post", mem_if.memReadReq, 0);
    endtask

    localparam logic [31:0] TD = 32'hF580_1234;

    initial begin
        reset = 1;
        loadValid_execute = 0;
        funct3_execute = 0;
        bytewiseAddress_execute = 0;
        rdIndex_execute = 0;
        flush = 0;
        mem_if.memReadAck = 0;
        mem_if.memReadData = 0;
        @(negedge clock);
        chk("rst_req", mem_if.memReadReq, 0);
        chk("rst_addr", mem_if.memAddress, 0);
        chk("rst_mask", mem_if.memByteMask, 0);
        chk("rst_wb", loadValid_writeback, 0);
        chk("rst_data", loadData_writeback, 0);
        chk("rst_rd", rdIndex_writeback, 0);
        chk("rst_fault", loadFault, 0);
        chk("rst_ready", loadReady, 1);
        chk("rst_stall", stall, 0);
        @(negedge clock);
        reset = 0;
        @(negedge clock);

        // Directed: extraction table, back-to-back.
        do_load(3'b000, 32'h0000_1000, 5'd1, 0, -1, TD);
        do_load(3'b100, 32'h0000_1001, 5'd2, 0, -1, TD);
        do_load(3'b001, 32'h0000_1000, 5'd3, 0, -1, TD);
        do_load(3'b101, 32'h0000_1002, 5'd4, 0, -1, TD);
        do_load(3'b010, 32'h0000_1000, 5'd5, 0, -1, TD);
        do_load(3'b010, 32'hABCD_0004, 5'd6, 5, -1, TD);      // delayed ack
        do_load(3'b010, 32'h0000_2000, 5'd7, 3, 0, TD);       // flush then drain
        do_load(3'b000, 32'h0000_2003, 5'd8, 2, 2, TD);       // flush with ack
        do_load(3'b010, 32'h0000_3000, 5'd9, 100, -1, TD);    // timeout
        do_load(3'b001, 32'h0000_4001, 5'd10, 0, -1, TD);     // misaligned half
        do_load(3'b011, 32'h0000_4000, 5'd11, 0, -1, TD);     // illegal funct3
        @(negedge clock);
        chk("idle_wb", loadValid_writeback, 0);
        chk("idle_fault", loadFault, 0);

        // Flushed request in IDLE is not accepted, even an illegal one.
        loadValid_execute = 1;
        funct3_execute = 3'b111;
        flush = 1;
        @(negedge clock);
        chk("idleflush_req", mem_if.memReadReq, 0);
        chk("idleflush_fault", loadFault, 0);
        funct3_execute = 3'b010;
        @(negedge clock);
        chk("idleflush_req2", mem_if.memReadReq, 0);
        chk("idleflush_ready", loadReady, 1);
        loadValid_execute = 0;
        flush = 0;
        @(negedge clock);

        // Reset mid-transaction drops the request; a late ack is ignored.
        loadValid_execute = 1;
        funct3_execute = 3'b010;
        bytewiseAddress_execute = 32'h0000_5000;
        @(negedge clock);
        loadValid_execute = 0;
        chk("mid_req", mem_if.memReadReq, 1);
        reset = 1;
        #1;
        chk("mid_rst_req", mem_if.memReadReq, 0);
        @(negedge clock);
        reset = 0;
        mem_if.memReadAck = 1;
        mem_if.memReadData = TD;
        @(negedge clock);
        mem_if.memReadAck = 0;
        chk("mid_wb", loadValid_writeback, 0);
        chk("mid_ready", loadReady, 1);
        chk("mid_req_after", mem_if.memReadReq, 0);

        // Randomized loads with random gaps, delays, timeouts and flushes.
        for (int n = 0; n < 300; n++) begin
            int aa, ff;
            aa = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 9));
            ff = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1;
            do_load(3'($urandom), $urandom, 5'($urandom), aa, ff, $urandom);
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clock);
                chk("gap_wb", loadValid_writeback, 0);
                chk("gap_fault", loadFault, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
